// File: rtl/tmds_word_aligner.sv
// TMDS receive word aligner: hunts control-token runs, pulses bitslip until aligned, watches for lock loss.
// Latency: dout is din delayed 1 cycle; all status outputs are registered. No backpressure; consumes one word per cycle.
module tmds_word_aligner #(
    parameter int RUN_LEN       = 8,
    parameter int WINDOW        = 4096,
    parameter int SETTLE_CYCLES = 16,
    parameter int MISS_LIMIT    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [9:0] din,
    output logic [9:0] dout,
    output logic       bitslip,
    output logic       locked,
    output logic [3:0] slip_count,
    output logic       wrap_error
);

    localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int MW = $clog2(MISS_LIMIT + 1);

    localparam logic [7:0]    RUN_MAX     = 8'(RUN_LEN);
    localparam logic [7:0]    RUN_LAST    = 8'(RUN_LEN - 1);
    localparam logic [WW-1:0] WIN_LAST    = WW'(WINDOW - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [MW-1:0] MISS_LAST   = MW'(MISS_LIMIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEARCH = 3'd1,
        SLIP   = 3'd2,
        SETTLE = 3'd3,
        LOCKED = 3'd4
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [7:0]    run_cnt;
    logic [WW-1:0] win_cnt;
    logic [SW-1:0] settle_cnt;
    logic [MW-1:0] miss_cnt;

    logic          is_token;
    logic          run_hit;
    logic          win_end;
    logic          hunting;

    logic          bitslip_nxt;
    logic          locked_nxt;
    logic          wrap_nxt;
    logic [3:0]    slip_nxt;

    always_comb begin
        is_token = (din == 10'b1101010100) || (din == 10'b0010101011) ||
                   (din == 10'b0101010100) || (din == 10'b1010101011);
    end

    // Runs are only counted while looking for or watching a boundary.
    assign hunting = (state == SEARCH) || (state == LOCKED);
    assign run_hit = hunting && (run_cnt == RUN_LAST) && is_token;
    assign win_end = (win_cnt == WIN_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            dout       <= '0;
            bitslip    <= 1'b0;
            locked     <= 1'b0;
            slip_count <= '0;
            wrap_error <= 1'b0;
        end else begin
            state      <= next_state;
            dout       <= din;
            bitslip    <= bitslip_nxt;
            locked     <= locked_nxt;
            slip_count <= slip_nxt;
            wrap_error <= wrap_nxt;
        end
    end

    always_comb begin
        next_state = state;
        if (!enable) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    next_state = SEARCH;
                SEARCH: begin
                    if (run_hit)      next_state = LOCKED;
                    else if (win_end) next_state = SLIP;
                end
                SLIP:    next_state = SETTLE;
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) next_state = SEARCH;
                end
                LOCKED: begin
                    // Lock drops to SEARCH at the current position; no slip first.
                    if (!run_hit && win_end && (miss_cnt == MISS_LAST)) next_state = SEARCH;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Outputs are computed from next_state so they are registered with the state.
    always_comb begin
        bitslip_nxt = (next_state == SLIP);
        locked_nxt  = (next_state == LOCKED);
        wrap_nxt    = 1'b0;
        slip_nxt    = slip_count;
        if (next_state == SLIP) begin
            if (slip_count == 4'd9) begin
                slip_nxt = 4'd0;
                wrap_nxt = 1'b1;
            end else begin
                slip_nxt = slip_count + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt    <= '0;
            win_cnt    <= '0;
            settle_cnt <= '0;
            miss_cnt   <= '0;
        end else begin
            if (hunting) begin
                if (!is_token)              run_cnt <= '0;
                else if (run_cnt != RUN_MAX) run_cnt <= run_cnt + 8'd1;
                win_cnt <= (run_hit || win_end) ? '0 : win_cnt + 1'b1;
            end else begin
                run_cnt <= '0;
                win_cnt <= '0;
            end

            if (state == SETTLE) settle_cnt <= settle_cnt + 1'b1;
            else                 settle_cnt <= '0;

            if (state == LOCKED) begin
                if (run_hit)      miss_cnt <= '0;
                else if (win_end) miss_cnt <= miss_cnt + 1'b1;
            end else begin
                miss_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_tmds_word_aligner.sv
// Directed bench for tmds_word_aligner with RUN_LEN=4, WINDOW=32, SETTLE_CYCLES=4, MISS_LIMIT=2.
module tb_tmds_word_aligner;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [9:0] din;
    logic [9:0] dout;
    logic       bitslip;
    logic       locked;
    logic [3:0] slip_count;
    logic       wrap_error;

    int vectors = 0;
    int miscompares = 0;

    tmds_word_aligner #(
        .RUN_LEN(4), .WINDOW(32), .SETTLE_CYCLES(4), .MISS_LIMIT(2)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .din(din), .dout(dout),
        .bitslip(bitslip), .locked(locked), .slip_count(slip_count), .wrap_error(wrap_error)
    );

    always #5 clk = ~clk;

    localparam logic [9:0] T0 = 10'h354;
    localparam logic [9:0] T1 = 10'h0AB;
    localparam logic [9:0] T2 = 10'h154;
    localparam logic [9:0] T3 = 10'h2AB;
    localparam logic [9:0] DAT = 10'h155;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_ticks(input int n, output logic bs_any, output logic lk_any, output logic lk_all);
        bs_any = 1'b0;
        lk_any = 1'b0;
        lk_all = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bitslip === 1'b1) bs_any = 1'b1;
            if (locked === 1'b1) lk_any = 1'b1;
            else                 lk_all = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0;
        din = 10'h000;
        tick();
        reset = 1'b0;
    endtask

    task automatic do_lock(input string tag);
        do_reset();
        enable = 1'b1;
        tick();
        din = T0; tick();
        din = T1; tick();
        din = T2; tick();
        din = T3; tick();
        chk(tag, {9'd0, locked}, 10'd1);
    endtask

    function automatic logic [9:0] nontok();
        logic [9:0] v;
        v = 10'($urandom_range(0, 1023));
        if (v == T0 || v == T1 || v == T2 || v == T3) v = v ^ 10'h001;
        return v;
    endfunction

    logic bs, lka, lkl;

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        din = 10'h3FF;
        tick();
        chk("rst_dout", dout, 10'h000);
        chk("rst_bitslip", {9'd0, bitslip}, 10'd0);
        chk("rst_locked", {9'd0, locked}, 10'd0);
        chk("rst_slip_count", {6'd0, slip_count}, 10'd0);
        chk("rst_wrap", {9'd0, wrap_error}, 10'd0);

        // 1: four tokens lock on the following cycle
        reset = 1'b0;
        enable = 1'b1;
        din = 10'h000;
        tick();
        din = T0;
        chk("t1_dout_delay", dout, 10'h000);
        tick();
        chk("t1_dout0", dout, T0);
        din = T1; tick();
        chk("t1_dout1", dout, T1);
        din = T2; tick();
        chk("t1_dout2", dout, T2);
        chk("t1_not_yet_locked", {9'd0, locked}, 10'd0);
        din = T3; tick();
        chk("t1_locked", {9'd0, locked}, 10'd1);
        chk("t1_dout3", dout, T3);
        run_ticks(5, bs, lka, lkl);
        chk("t1_no_bitslip", {9'd0, bs}, 10'd0);
        chk("t1_slip_count", {6'd0, slip_count}, 10'd0);

        // 2: no tokens, bitslip every 37 cycles, wrap on the 10th
        do_reset();
        enable = 1'b1;
        din = DAT;
        tick();
        for (int k = 1; k <= 10; k++) begin
            run_ticks((k == 1) ? 31 : 36, bs, lka, lkl);
            chk($sformatf("t2_quiet_%0d", k), {9'd0, bs}, 10'd0);
            tick();
            chk($sformatf("t2_pulse_%0d", k), {9'd0, bitslip}, 10'd1);
            chk($sformatf("t2_slip_count_%0d", k), {6'd0, slip_count}, 10'(k % 10));
            chk($sformatf("t2_wrap_%0d", k), {9'd0, wrap_error}, (k == 10) ? 10'd1 : 10'd0);
        end
        tick();
        chk("t2_pulse_one_cycle", {9'd0, bitslip}, 10'd0);
        chk("t2_wrap_one_cycle", {9'd0, wrap_error}, 10'd0);

        // 3: lock loss after two empty windows, then a full window before slipping
        do_lock("t3_lock");
        for (int i = 0; i < 63; i++) begin
            din = nontok();
            tick();
            if (locked !== 1'b1) lkl = 1'b0;
        end
        chk("t3_dout_tracks", dout, din);
        din = nontok();
        tick();
        chk("t3_lock_lost", {9'd0, locked}, 10'd0);
        bs = 1'b0;
        for (int i = 0; i < 31; i++) begin
            din = nontok();
            tick();
            if (bitslip === 1'b1) bs = 1'b1;
        end
        chk("t3_no_early_slip", {9'd0, bs}, 10'd0);
        din = nontok();
        tick();
        chk("t3_slip_after_window", {9'd0, bitslip}, 10'd1);
        chk("t3_slip_count", {6'd0, slip_count}, 10'd1);

        // 4: runs of 3 never lock; a run of 4 ending on the last window word locks
        do_reset();
        enable = 1'b1;
        din = DAT;
        tick();
        lka = 1'b0;
        bs = 1'b0;
        for (int g = 0; g < 7; g++) begin
            for (int j = 0; j < 4; j++) begin
                din = (j == 3) ? DAT : T1;
                tick();
                if (locked === 1'b1) lka = 1'b1;
                if (bitslip === 1'b1) bs = 1'b1;
            end
        end
        chk("t4_run3_no_lock", {9'd0, lka}, 10'd0);
        for (int j = 0; j < 4; j++) begin
            din = T2;
            tick();
            if (bitslip === 1'b1) bs = 1'b1;
        end
        chk("t4_lock_on_last_word", {9'd0, locked}, 10'd1);
        chk("t4_no_slip", {9'd0, bs}, 10'd0);
        chk("t4_slip_count", {6'd0, slip_count}, 10'd0);

        // 5: enable dropped in SETTLE
        do_reset();
        enable = 1'b1;
        din = DAT;
        tick();
        run_ticks(32, bs, lka, lkl);
        chk("t5_slip", {9'd0, bitslip}, 10'd1);
        tick();
        enable = 1'b0;
        tick();
        chk("t5_idle_bitslip", {9'd0, bitslip}, 10'd0);
        chk("t5_idle_locked", {9'd0, locked}, 10'd0);
        run_ticks(50, bs, lka, lkl);
        chk("t5_idle_no_slip", {9'd0, bs}, 10'd0);
        chk("t5_idle_slip_count", {6'd0, slip_count}, 10'd1);
        enable = 1'b1;
        tick();
        run_ticks(31, bs, lka, lkl);
        chk("t5_search_quiet", {9'd0, bs}, 10'd0);
        tick();
        chk("t5_resume_slip", {9'd0, bitslip}, 10'd1);
        chk("t5_resume_count", {6'd0, slip_count}, 10'd2);

        // 6: reset in LOCKED and in SLIP
        do_lock("t6_lock");
        reset = 1'b1;
        tick();
        chk("t6_lk_dout", dout, 10'h000);
        chk("t6_lk_locked", {9'd0, locked}, 10'd0);
        chk("t6_lk_bitslip", {9'd0, bitslip}, 10'd0);
        reset = 1'b0;
        enable = 1'b1;
        din = DAT;
        tick();
        run_ticks(32, bs, lka, lkl);
        chk("t6_in_slip", {9'd0, bitslip}, 10'd1);
        reset = 1'b1;
        tick();
        chk("t6_sl_dout", dout, 10'h000);
        chk("t6_sl_bitslip", {9'd0, bitslip}, 10'd0);
        chk("t6_sl_locked", {9'd0, locked}, 10'd0);
        chk("t6_sl_slip_count", {6'd0, slip_count}, 10'd0);
        chk("t6_sl_wrap", {9'd0, wrap_error}, 10'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tmds_word_aligner.md
Name: tmds_word_aligner

Overview:
Receive-side companion to the transmit clock-divide/serializer path. Operates in the divided (parallel-word) clock domain and takes 10-bit words from a 1:10 deserializer. Finds TMDS word boundaries by hunting for runs of control tokens during blanking, and pulses the deserializer bitslip until a run is found. Reports lock and keeps watching for loss of lock.

Parameters:
RUN_LEN, 8, consecutive control-token words needed to declare a valid run (range 2..255)
WINDOW, 4096, words searched per slip position; also the loss-watch period in LOCKED (must exceed one video line)
SETTLE_CYCLES, 16, idle words after each bitslip pulse before the search resumes (≥1)
MISS_LIMIT, 4, consecutive windows without a run, while LOCKED, that drop lock

Ports:
clk  input  1  divided pixel clock; everything here is in this domain
reset  input  1  synchronous, active-high
enable  input  1  alignment active; low forces IDLE
din  input  10  raw deserializer word
dout  output  10  din registered, 1-cycle latency
bitslip  output  1  one-cycle pulse to the deserializer
locked  output  1  word boundary found
slip_count  output  4  current slip position, 0..9
wrap_error  output  1  one-cycle pulse when slip_count wraps 9→0

Behaviour:
- Control tokens: 1101010100, 0010101011, 0101010100, 1010101011. is_token is combinational on din.
- run_cnt:
  - Increments on is_token, saturating at RUN_LEN. Clears to 0 on a non-token.
  - run_hit = (run_cnt == RUN_LEN-1) && is_token, i.e. the cycle the RUN_LEN-th consecutive token arrives.
- Reset values: dout=0, bitslip=0, locked=0, slip_count=0, wrap_error=0. State=IDLE, all counters 0.
- dout <= din every cycle, independent of state and enable. It clears only on reset.
- States: IDLE, SEARCH, SLIP, SETTLE, LOCKED.
- IDLE:
  - Counters are held at 0.
  - enable=1 → SEARCH next cycle.
  - slip_count keeps its value across IDLE (the last good position is a good starting guess). It clears only on reset.
- SEARCH:
  - win_cnt counts 0..WINDOW-1.
  - run_hit → LOCKED.
  - Otherwise, win_cnt==WINDOW-1 → SLIP.
  - If both happen on the same cycle, run_hit wins.
- SLIP:
  - Lasts exactly one cycle, with bitslip=1.
  - slip_count increments. 9→0 wraps and pulses wrap_error in the same cycle as bitslip.
  - → SETTLE.
- SETTLE:
  - Counts SETTLE_CYCLES cycles. run_cnt and win_cnt are held at 0.
  - → SEARCH.
- LOCKED:
  - locked=1 is registered and asserts the cycle after run_hit.
  - win_cnt restarts on every run_hit and clears miss_cnt.
  - On win_cnt==WINDOW-1 with no run_hit, miss_cnt increments and win_cnt wraps to 0.
  - When miss_cnt reaches MISS_LIMIT → SEARCH. locked deasserts the next cycle and no slip is issued (search at the current position first).
  - run_hit on the same cycle as the final miss: the run_hit wins and lock is kept.
- enable=0, from any state → IDLE next cycle; locked=0 and bitslip=0 from then on.
- A bitslip pulse already issued is never truncated (it is one cycle by construction).
- reset has priority over enable and every transition. Asserting it mid-SLIP or mid-SETTLE returns to the reset values next cycle.
- bitslip pulses are never closer together than SETTLE_CYCLES+WINDOW+1 cycles.

Test Plan (bench params: RUN_LEN=4, WINDOW=32, SETTLE_CYCLES=4, MISS_LIMIT=2):
1. Reset, enable=1, then 4 words of 1101010100 → locked=1 on the cycle after the 4th token; bitslip never pulses; slip_count=0. dout tracks din with 1-cycle delay.
2. din=0x155 (non-token) constantly → bitslip pulses every 37 cycles (32+1+4); slip_count steps 0..9; on the 10th pulse slip_count=0 and wrap_error=1 on that same cycle.
3. Locked, then random non-token data → locked falls after 2×32 cycles without a run, returns to SEARCH; no bitslip pulse inside the first 32 cycles of SEARCH.
4. Token runs of length 3 interrupted by data → never locks (the run_cnt clear is verified). Then run of exactly 4 ending on win_cnt=31 → LOCKED, not SLIP.
5. enable dropped during SETTLE → IDLE next cycle, no further bitslip. Re-enable → SEARCH with slip_count preserved.
6. reset pulse during LOCKED and during SLIP → all outputs return to their reset values (dout=0, bitslip=0, locked=0, slip_count=0, wrap_error=0) on the next cycle.
